// File: rtl/spi_params.sv
// rtl/spi_params.sv - shared SPI frame constants, command codes and FSM stage encodings
package spi_params;

  localparam int MASTER_FRAME_WIDTH = 24;
  localparam int CMD_BITS           = 8;
  localparam int ADDR_BITS          = 8;
  localparam int PAYLOAD_BITS       = 8;
  localparam int BIT_CNT_WIDTH      = 5;
  localparam int SLAVE_CLK_NS       = 8;

  localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRANSFER = 3'd1,
    ST_DONE     = 3'd2,
    ST_ABORT    = 3'd3
  } spi_stage_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchronizer with rising/falling edge detect
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two synchronizer stages plus one delay stage used only for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 slave, 24-bit frames; SPI_SLAVE_DEBUG_EN exposes internal debug state
module spi_slave_ctrl
  import spi_params::*;
(
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          sclk,
  input  logic                          cs,
  input  logic                          mosi,
  input  logic                          slv_tx_enb,
  input  logic [MASTER_FRAME_WIDTH-1:0] i_slv_frame,
  output logic                          miso,
  output logic [CMD_BITS-1:0]           o_cmd,
  output logic [ADDR_BITS-1:0]          o_addr,
  output logic [PAYLOAD_BITS-1:0]       o_payload,
  output logic                          rx_dv,
  output logic [MASTER_FRAME_WIDTH-1:0] o_shift_reg_debug,
  output logic                          o_serial_debug,
  output logic [BIT_CNT_WIDTH-1:0]      o_bit_rx_cnt_debug,
  output logic [2:0]                    o_debug_stage
);

  localparam logic [BIT_CNT_WIDTH-1:0] FRAME_BITS = BIT_CNT_WIDTH'(MASTER_FRAME_WIDTH);
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT   = BIT_CNT_WIDTH'(MASTER_FRAME_WIDTH - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_meta, mosi_sync;

  spi_stage_e state, state_next;

  logic [MASTER_FRAME_WIDTH-1:0] shift_q;
  logic [MASTER_FRAME_WIDTH-1:0] tx_q;
  logic [BIT_CNT_WIDTH-1:0]      bit_cnt;
  logic                          tx_shift_pending;
  logic                          frame_full;
  logic                          last_bit_now;
  logic                          start_frame;
  logic                          unused_sync;

  spi_sync_edge u_sclk_sync (
    .clk      (sysclk),
    .rst_n    (rst_n),
    .async_in (sclk),
    .sync_out (sclk_sync),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge u_cs_sync (
    .clk      (sysclk),
    .rst_n    (rst_n),
    .async_in (cs),
    .sync_out (cs_sync),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // Only edges of sclk/cs drive the logic; their levels are deliberately left unused
  assign unused_sync = &{1'b0, sclk_sync, sclk_fall, cs_sync};

  // mosi needs the same 2-cycle delay as sclk so data lines up with the detected edge
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign frame_full   = (bit_cnt == FRAME_BITS);
  // A cs rise that lands on the 24th sample must not abort the frame
  assign last_bit_now = sclk_rise && (bit_cnt == LAST_BIT);
  assign start_frame  = (state == ST_IDLE) && cs_fall;

  // FSM state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: full frame wins over a coincident cs rise
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cs_fall) state_next = ST_TRANSFER;
      end
      ST_TRANSFER: begin
        if (frame_full) begin
          state_next = ST_DONE;
        end else if (cs_rise && !last_bit_now) begin
          state_next = ST_ABORT;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Receive shift register and bit counter; samples beyond 24 bits are ignored
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q          <= '0;
      bit_cnt          <= '0;
      tx_shift_pending <= 1'b0;
    end else begin
      tx_shift_pending <= 1'b0;
      if (start_frame) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else if ((state == ST_TRANSFER) && sclk_rise && !frame_full) begin
        shift_q          <= {shift_q[MASTER_FRAME_WIDTH-2:0], mosi_sync};
        bit_cnt          <= bit_cnt + 1'b1;
        tx_shift_pending <= 1'b1;
      end
    end
  end

  // Transmit register: loaded at frame start, advanced one cycle after each sample
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (start_frame) begin
      tx_q <= slv_tx_enb ? i_slv_frame : '0;
    end else if ((state == ST_TRANSFER) && tx_shift_pending) begin
      tx_q <= {tx_q[MASTER_FRAME_WIDTH-2:0], 1'b0};
    end
  end

  // Field outputs and rx_dv update together as the FSM enters DONE
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      o_cmd     <= '0;
      o_addr    <= '0;
      o_payload <= '0;
      rx_dv     <= 1'b0;
    end else begin
      rx_dv <= (state_next == ST_DONE);
      if (state_next == ST_DONE) begin
        o_cmd     <= shift_q[MASTER_FRAME_WIDTH-1 -: CMD_BITS];
        o_addr    <= shift_q[PAYLOAD_BITS +: ADDR_BITS];
        o_payload <= shift_q[0 +: PAYLOAD_BITS];
      end
    end
  end

  assign miso = (state == ST_TRANSFER) ? tx_q[MASTER_FRAME_WIDTH-1] : 1'b0;

`ifdef SPI_SLAVE_DEBUG_EN
  assign o_shift_reg_debug  = shift_q;
  assign o_serial_debug     = mosi_sync;
  assign o_bit_rx_cnt_debug = bit_cnt;
  assign o_debug_stage      = state;
`else
  assign o_shift_reg_debug  = '0;
  assign o_serial_debug     = 1'b0;
  assign o_bit_rx_cnt_debug = '0;
  assign o_debug_stage      = 3'd0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - table-driven self-checking bench for spi_slave_ctrl
module tb_spi_slave_ctrl;
  import spi_params::*;

  localparam int HALF     = 5;
  localparam int SETUP    = 6;
  localparam int IDLE_GAP = 8;
  localparam int NVEC     = 7;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        slv_tx_enb;
  logic [23:0] i_slv_frame;
  logic        miso;
  logic [7:0]  o_cmd, o_addr, o_payload;
  logic        rx_dv;
  logic [23:0] o_shift_reg_debug;
  logic        o_serial_debug;
  logic [4:0]  o_bit_rx_cnt_debug;
  logic [2:0]  o_debug_stage;

  int n_checks = 0;
  int n_pass   = 0;
  int dv_count = 0;

  typedef struct {
    logic [23:0] frame;
    logic        tx_enb;
    logic [23:0] tx_frame;
    int          nbits;
    int          extra;
    logic        cs_last;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [7:0]  pay;
    int          dvs;
    logic [23:0] miso_exp;
    int          lat;
  } vec_t;

  vec_t vecs [NVEC];

  spi_slave_ctrl dut (
    .sysclk             (sysclk),
    .rst_n              (rst_n),
    .sclk               (sclk),
    .cs                 (cs),
    .mosi               (mosi),
    .slv_tx_enb         (slv_tx_enb),
    .i_slv_frame        (i_slv_frame),
    .miso               (miso),
    .o_cmd              (o_cmd),
    .o_addr             (o_addr),
    .o_payload          (o_payload),
    .rx_dv              (rx_dv),
    .o_shift_reg_debug  (o_shift_reg_debug),
    .o_serial_debug     (o_serial_debug),
    .o_bit_rx_cnt_debug (o_bit_rx_cnt_debug),
    .o_debug_stage      (o_debug_stage)
  );

  always #(SLAVE_CLK_NS / 2) sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (rx_dv === 1'b1) dv_count = dv_count + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, input logic cs_up, output logic m, output int lat);
    mosi = b;
    repeat (HALF) @(negedge sysclk);
    m = miso;
    sclk = 1'b1;
    if (cs_up) cs = 1'b1;
    lat = 0;
    for (int k = 1; k <= HALF; k++) begin
      @(negedge sysclk);
      if (rx_dv === 1'b1 && lat == 0) lat = k;
    end
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] data, input int nbits, input int extra,
                            input logic cs_last, output logic [23:0] cap, output int lat);
    logic m;
    int   l;
    cap = '0;
    lat = 0;
    cs  = 1'b0;
    repeat (SETUP) @(negedge sysclk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(data[23-i], cs_last && (i == nbits - 1), m, l);
      cap = {cap[22:0], m};
      if (i == nbits - 1) lat = l;
    end
    for (int i = 0; i < extra; i++) begin
      spi_bit(1'b1, 1'b0, m, l);
    end
    repeat (HALF) @(negedge sysclk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (IDLE_GAP) @(negedge sysclk);
  endtask

  initial begin
    logic [23:0] cap;
    int          lat;
    int          dv0;
    logic        m;
    int          l;

    vecs[0] = '{24'h81A1D1, 1'b0, 24'h000000, 24, 0, 1'b0, 8'h81, 8'hA1, 8'hD1, 1, 24'h000000, 4};
    vecs[1] = '{{CMD_LED_SET, 8'h02, 8'h0A}, 1'b0, 24'h000000, 24, 0, 1'b0, 8'h01, 8'h02, 8'h0A, 1, 24'h000000, 4};
    vecs[2] = '{{CMD_LED_SET, 8'h09, 8'h05}, 1'b1, 24'h00000A, 24, 0, 1'b0, 8'h01, 8'h09, 8'h05, 1, 24'h00000A, 4};
    vecs[3] = '{24'hFFFFFF, 1'b0, 24'h000000, 10, 0, 1'b0, 8'h01, 8'h09, 8'h05, 0, 24'h000000, 0};
    vecs[4] = '{24'h123456, 1'b0, 24'h000000, 24, 0, 1'b0, 8'h12, 8'h34, 8'h56, 1, 24'h000000, 4};
    vecs[5] = '{24'hA5C3F0, 1'b1, 24'hC0FFEE, 24, 4, 1'b0, 8'hA5, 8'hC3, 8'hF0, 1, 24'hC0FFEE, 4};
    vecs[6] = '{24'h5A5A5A, 1'b1, 24'h800001, 24, 0, 1'b1, 8'h5A, 8'h5A, 8'h5A, 1, 24'h800001, 4};

    rst_n       = 1'b0;
    sclk        = 1'b0;
    cs          = 1'b1;
    mosi        = 1'b0;
    slv_tx_enb  = 1'b0;
    i_slv_frame = '0;
    repeat (3) @(negedge sysclk);

    chk("reset o_cmd", 32'(o_cmd), 32'h0);
    chk("reset o_addr", 32'(o_addr), 32'h0);
    chk("reset o_payload", 32'(o_payload), 32'h0);
    chk("reset rx_dv", 32'(rx_dv), 32'h0);
    chk("reset miso", 32'(miso), 32'h0);
    chk("reset stage", 32'(o_debug_stage), 32'h0);

    rst_n = 1'b1;
    repeat (IDLE_GAP) @(negedge sysclk);

    for (int i = 0; i < NVEC; i++) begin
      slv_tx_enb  = vecs[i].tx_enb;
      i_slv_frame = vecs[i].tx_frame;
      dv0 = dv_count;
      send_frame(vecs[i].frame, vecs[i].nbits, vecs[i].extra, vecs[i].cs_last, cap, lat);
      chk($sformatf("v%0d o_cmd", i), 32'(o_cmd), 32'(vecs[i].cmd));
      chk($sformatf("v%0d o_addr", i), 32'(o_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d o_payload", i), 32'(o_payload), 32'(vecs[i].pay));
      chk($sformatf("v%0d rx_dv pulses", i), 32'(dv_count - dv0), 32'(vecs[i].dvs));
      chk($sformatf("v%0d miso stream", i), 32'(cap), 32'(vecs[i].miso_exp));
      chk($sformatf("v%0d rx_dv latency", i), 32'(lat), 32'(vecs[i].lat));
      if (i == 0) begin
`ifdef SPI_SLAVE_DEBUG_EN
        chk("dbg shift", 32'(o_shift_reg_debug), 32'h81A1D1);
        chk("dbg count", 32'(o_bit_rx_cnt_debug), 32'd24);
        chk("dbg stage", 32'(o_debug_stage), 32'(ST_IDLE));
        chk("dbg serial", 32'(o_serial_debug), 32'h0);
`else
        chk("dbg shift", 32'(o_shift_reg_debug), 32'h0);
        chk("dbg count", 32'(o_bit_rx_cnt_debug), 32'h0);
        chk("dbg stage", 32'(o_debug_stage), 32'h0);
        chk("dbg serial", 32'(o_serial_debug), 32'h0);
`endif
      end
    end

    // Reset in the middle of a transmitting frame
    slv_tx_enb  = 1'b1;
    i_slv_frame = 24'hFFFFFF;
    cs = 1'b0;
    repeat (SETUP) @(negedge sysclk);
    for (int i = 0; i < 12; i++) spi_bit(1'b1, 1'b0, m, l);
    chk("pre-reset miso", 32'(miso), 32'h1);
    @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    chk("mid reset o_cmd", 32'(o_cmd), 32'h0);
    chk("mid reset o_addr", 32'(o_addr), 32'h0);
    chk("mid reset o_payload", 32'(o_payload), 32'h0);
    chk("mid reset rx_dv", 32'(rx_dv), 32'h0);
    chk("mid reset miso", 32'(miso), 32'h0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    dv0 = dv_count;
    for (int i = 0; i < 24; i++) spi_bit(1'b1, 1'b0, m, l);
    chk("post-reset no frame dv", 32'(dv_count - dv0), 32'h0);
    chk("post-reset o_cmd", 32'(o_cmd), 32'h0);
    chk("post-reset miso", 32'(miso), 32'h0);
    repeat (HALF) @(negedge sysclk);
    cs = 1'b1;
    repeat (IDLE_GAP) @(negedge sysclk);

    slv_tx_enb = 1'b0;
    dv0 = dv_count;
    send_frame(24'hABCDEF, 24, 0, 1'b0, cap, lat);
    chk("after reset o_cmd", 32'(o_cmd), 32'hAB);
    chk("after reset o_addr", 32'(o_addr), 32'hCD);
    chk("after reset o_payload", 32'(o_payload), 32'hEF);
    chk("after reset rx_dv pulses", 32'(dv_count - dv0), 32'h1);
    chk("after reset latency", 32'(lat), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
